// File: rtl/status_event_collector_pkg.sv
// status_event_pkg
// Shared constants for the status event collector and its record FIFO.
// The record layout depends on the instance count chosen at the top level.
// It also depends on whether the timestamp field is compiled in. For both
// reasons the record struct is declared in the top module. It reaches the
// FIFO through a type parameter, so the idx field width follows the
// user-chosen INSTANCES.
package status_event_pkg;

  // Width of the free-running cycle counter and of the stored timestamp.
  localparam int TIME_W = 16;

endpackage

// File: rtl/status_event_collector_fifo.sv
// status_event_fifo
// DEPTH-entry synchronous FIFO of event records. Reset is synchronous and
// active-high.
// Ports:
//   clk, rst      clock and synchronous reset
//   push_i        write push_data_i at the tail; ignored when full
//   push_data_i   record to write
//   pop_i         advance the head; ignored when empty
//   full_o        all DEPTH entries occupied
//   empty_o       no entries stored
//   head_o        record at the head. It is stale when empty_o=1, so the
//                 consumer must qualify it.
module status_event_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  entry_t         mem_q [DEPTH];
  // Pointers carry one extra wrap bit so that full and empty can be told
  // apart when the index bits are equal.
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
               (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    head_o   = mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only observed after it is written.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/status_event_collector.sv
// status_event_collector
// Watches INSTANCES status bits. Each level change becomes a pending bit.
// Pending bits are serialised, lowest index first, into a record FIFO. The
// FIFO is drained over a valid/ready stream.
// Optional feature macro: STATUS_EVENT_COLLECTOR_TIMESTAMP_EN. When it is
// defined, a 16-bit cycle counter stamps every record. When it is undefined,
// no counter or time field exists and ev_time_o is tied to 0.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   sample_i      per-instance status bits, sampled every edge
//   ev_valid_o    a record is available at the FIFO head
//   ev_ready_i    consumer accepts the head record
//   ev_idx_o      instance index of the head record
//   ev_val_o      reported value of that instance
//   ev_time_o     cycle stamp of the head record (0 when compiled out)
//   pending_o     a detected change is not yet queued
//   idle_o        baseline captured, nothing pending, FIFO empty
// Stream handshake: a record transfers on every edge where ev_valid_o and
// ev_ready_i are both 1. While ev_valid_o=1 and ev_ready_i=0, the payload
// holds. ev_valid_o never depends on ev_ready_i.
module status_event_collector
  import status_event_pkg::*;
#(
  parameter  int INSTANCES = 10,
  parameter  int DEPTH     = 4,
  localparam int IDX_W     = $clog2(INSTANCES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INSTANCES-1:0] sample_i,
  output logic                 ev_valid_o,
  input  logic                 ev_ready_i,
  output logic [IDX_W-1:0]     ev_idx_o,
  output logic                 ev_val_o,
  output logic [TIME_W-1:0]    ev_time_o,
  output logic                 pending_o,
  output logic                 idle_o
);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              val;
`ifdef STATUS_EVENT_COLLECTOR_TIMESTAMP_EN
    logic [TIME_W-1:0] stamp;
`endif
  } status_event_t;

  logic [INSTANCES-1:0] prev_q, prev_d;
  logic [INSTANCES-1:0] pend_q, pend_d;
  logic                 base_q, base_d;

  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic [INSTANCES-1:0] sel_mask;
  logic                 sel_val;
  logic [INSTANCES-1:0] clr_mask;
  logic                 push;
  status_event_t        push_rec;
  status_event_t        head;
  logic                 fifo_full, fifo_empty;

`ifdef STATUS_EVENT_COLLECTOR_TIMESTAMP_EN
  logic [TIME_W-1:0]    cnt_q, cnt_d;

  always_comb cnt_d = cnt_q + TIME_W'(1);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  // Priority selector. The loop runs from the top down, so the lowest set
  // pending bit is the last one to overwrite the selection.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_mask  = '0;
    sel_val   = 1'b0;
    for (int i = INSTANCES - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_found   = 1'b1;
        sel_idx     = IDX_W'(i);
        sel_mask    = '0;
        sel_mask[i] = 1'b1;
        sel_val     = prev_q[i];
      end
    end
  end

  always_comb begin
    // A full FIFO blocks the push even when a pop happens on the same edge.
    push     = sel_found && !fifo_full;
    clr_mask = push ? sel_mask : '0;
    // The value comes from prev. While a bit waits in pend, prev keeps
    // tracking it, so a coalesced record reports the latest sample. A change
    // on the same edge as the push re-arms pend for a second record.
    push_rec     = '0;
    push_rec.idx = sel_idx;
    push_rec.val = sel_val;
`ifdef STATUS_EVENT_COLLECTOR_TIMESTAMP_EN
    push_rec.stamp = cnt_d;
`endif
    prev_d = sample_i;
    base_d = 1'b1;
    // The first edge after reset only captures the baseline.
    pend_d = base_q ? ((pend_q & ~clr_mask) | (sample_i ^ prev_q)) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      pend_q <= '0;
      base_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
      base_q <= base_d;
    end
  end

  status_event_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (status_event_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_rec),
    .pop_i       (ev_ready_i),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  // The head is gated with empty so that stale storage never shows on the
  // outputs. This covers the reset case too.
  always_comb begin
    ev_valid_o = !fifo_empty;
    ev_idx_o   = fifo_empty ? '0 : head.idx;
    ev_val_o   = fifo_empty ? 1'b0 : head.val;
`ifdef STATUS_EVENT_COLLECTOR_TIMESTAMP_EN
    ev_time_o  = fifo_empty ? '0 : head.stamp;
`else
    ev_time_o  = '0;
`endif
    pending_o  = |pend_q;
    idle_o     = base_q && !(|pend_q) && fifo_empty;
  end

endmodule

// File: tb/tb_status_event_collector.sv
module tb_status_event_collector;

  localparam int INSTANCES = 10;
  localparam int DEPTH     = 4;
  localparam int IDX_W     = 4;
  localparam int TIME_W    = 16;
  localparam int REC_W     = IDX_W + 1 + TIME_W;
`ifdef STATUS_EVENT_COLLECTOR_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [INSTANCES-1:0] sample_i = '0;
  logic                 ev_ready_i = 1'b0;
  logic                 ev_valid_o;
  logic [IDX_W-1:0]     ev_idx_o;
  logic                 ev_val_o;
  logic [TIME_W-1:0]    ev_time_o;
  logic                 pending_o;
  logic                 idle_o;

  always #5 clk = ~clk;

  status_event_collector #(.INSTANCES(INSTANCES), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_i   (sample_i),
    .ev_valid_o (ev_valid_o),
    .ev_ready_i (ev_ready_i),
    .ev_idx_o   (ev_idx_o),
    .ev_val_o   (ev_val_o),
    .ev_time_o  (ev_time_o),
    .pending_o  (pending_o),
    .idle_o     (idle_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model (scoreboard) ----------------
  // Record = {idx, val, time}; time = number of post-reset edges at the push.
  bit                   m_base;
  bit [INSTANCES-1:0]   m_prev, m_pend;
  int unsigned          m_cnt;
  logic [REC_W-1:0]     exp_q[$];

  task automatic model_edge(input bit r, input logic [INSTANCES-1:0] s, input bit rdy);
    int sel;
    bit was_full;
    if (r) begin
      m_base = 0; m_prev = '0; m_pend = '0; m_cnt = 0;
      exp_q.delete();
      return;
    end
    m_cnt    = (m_cnt + 1) % 65536;
    was_full = (exp_q.size() == DEPTH);
    sel = -1;
    if (!was_full)
      for (int i = INSTANCES - 1; i >= 0; i--) if (m_pend[i]) sel = i;
    if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
    if (sel >= 0) begin
      exp_q.push_back({IDX_W'(sel), m_prev[sel], TIME_W'(m_cnt)});
      m_pend[sel] = 1'b0;
    end
    if (m_base) m_pend = m_pend | (s ^ m_prev);
    m_prev = s;
    m_base = 1;
  endtask

  function automatic void compare_model();
    logic [23:0]      a, e;
    logic [REC_W-1:0] h;
    bit               e_valid;
    e_valid = (exp_q.size() > 0);
    a = {ev_valid_o, pending_o, idle_o, 21'h0};
    e = {e_valid, (m_pend != 0), (m_base && m_pend == 0 && !e_valid), 21'h0};
    if (e_valid) begin
      h = exp_q[0];
      a[20:0] = {ev_idx_o, ev_val_o, ev_time_o};
      e[20:0] = TS_EN ? h : {h[20:16], 16'h0};
    end
    check("model", 64'(a), 64'(e));
  endfunction

  // ---------------- driver ----------------
  // Called from a falling edge; drives, waits one rising edge, checks at the next falling edge.
  task automatic tick(input bit r, input logic [INSTANCES-1:0] s, input bit rdy);
    rst = r; sample_i = s; ev_ready_i = rdy;
    @(posedge clk);
    model_edge(r, s, rdy);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset(input logic [INSTANCES-1:0] s);
    tick(1'b1, s, 1'b1);
    tick(1'b0, s, 1'b1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit                 rst;
    logic [INSTANCES-1:0] s;
    bit                 rdy;
    bit                 v;
    logic [IDX_W-1:0]   idx;
    bit                 val;
    logic [TIME_W-1:0]  tm;
    bit                 pend;
    bit                 idle;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [INSTANCES-1:0] s;
    int got[$];
    int cnt2, val2, nvalid;
    int exp_c[6] = '{1, 2, 4, 6, 7, 9};

    // rows: inputs for one edge, outputs expected after that edge
    vt[0] = '{1'b1, 10'h000, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 10'h000, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b1};
    vt[2] = '{1'b0, 10'h000, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b1};
    vt[3] = '{1'b0, 10'h000, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b1};
    vt[4] = '{1'b0, 10'h000, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b1};
    vt[5] = '{1'b0, 10'h008, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0, 1'b1, 1'b0};
    vt[6] = '{1'b0, 10'h008, 1'b1, 1'b1, 4'd3, 1'b1, 16'd6, 1'b0, 1'b0};
    vt[7] = '{1'b0, 10'h008, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b1};

    for (int i = 0; i < 8; i++) begin
      tick(vt[i].rst, vt[i].s, vt[i].rdy);
      if (vt[i].v || vt[i].rst)
        check("vec_full", {ev_valid_o, ev_idx_o, ev_val_o, ev_time_o, pending_o, idle_o},
              {vt[i].v, vt[i].idx, vt[i].val, (TS_EN ? vt[i].tm : 16'h0), vt[i].pend, vt[i].idle});
      else
        check("vec_flags", {ev_valid_o, pending_o, idle_o}, {vt[i].v, vt[i].pend, vt[i].idle});
    end
    // quiet inputs: nothing is ever produced
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 10'h008, 1'b1);
      check("quiet_valid", ev_valid_o, 0);
    end

    // all bits rise at once: ten back-to-back records in index order
    do_reset(10'h000);
    tick(1'b0, 10'h3FF, 1'b1);
    for (int k = 0; k < INSTANCES; k++) begin
      tick(1'b0, 10'h3FF, 1'b1);
      check("burst_rec", {ev_valid_o, ev_idx_o, ev_val_o}, {1'b1, IDX_W'(k), 1'b1});
    end
    tick(1'b0, 10'h3FF, 1'b1);
    check("burst_end", ev_valid_o, 0);

    // backpressure: six changes, four fit, the rest wait in pend
    do_reset(10'h000);
    for (int i = 0; i < 7; i++) tick(1'b0, 10'h2D6, 1'b0);
    check("bp_full", {ev_valid_o, ev_idx_o, pending_o}, {1'b1, 4'd1, 1'b1});
    got.delete();
    for (int i = 0; i < 20 && got.size() < 6; i++) begin
      if (ev_valid_o) got.push_back(int'(ev_idx_o));
      tick(1'b0, 10'h2D6, 1'b1);
    end
    check("bp_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("bp_order", got[i], exp_c[i]);

    // coalescing: bit 2 toggles 0->1->0 while the FIFO is full
    do_reset(10'h000);
    for (int i = 0; i < 6; i++) tick(1'b0, 10'h01B, 1'b0);
    tick(1'b0, 10'h01F, 1'b0);
    tick(1'b0, 10'h01F, 1'b0);
    tick(1'b0, 10'h01B, 1'b0);
    tick(1'b0, 10'h01B, 1'b0);
    check("coal_pending", {pending_o, ev_valid_o}, 2'b11);
    cnt2 = 0; val2 = -1; got.delete();
    for (int i = 0; i < 15; i++) begin
      if (ev_valid_o) begin
        got.push_back(int'(ev_idx_o));
        if (ev_idx_o == 4'd2) begin cnt2++; val2 = int'(ev_val_o); end
      end
      tick(1'b0, 10'h01B, 1'b1);
    end
    check("coal_count", cnt2, 1);
    check("coal_val", val2, 0);
    check("coal_total", got.size(), 5);

    // reset with records queued
    do_reset(10'h000);
    for (int i = 0; i < 4; i++) tick(1'b0, 10'h0E0, 1'b0);
    check("rst_pre_valid", ev_valid_o, 1);
    tick(1'b1, 10'h0E0, 1'b0);
    check("rst_clear", {ev_valid_o, ev_time_o, pending_o, idle_o}, 19'h0);
    tick(1'b0, 10'h0E0, 1'b1);
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 10'h0E0, 1'b1);
      if (ev_valid_o) nvalid++;
    end
    check("rst_no_stale", nvalid, 0);

    // random traffic against the model
    s = '0;
    do_reset(s);
    for (int i = 0; i < 3000; i++) begin
      bit r, rdy;
      r = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 2) == 0) s[$urandom_range(0, INSTANCES - 1)] ^= 1'b1;
      if ($urandom_range(0, 59) == 0) s = INSTANCES'($urandom);
      rdy = ((i / 100) % 3 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      tick(r, s, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
